picoblaze_interrupt_controller: RTL and testbench
=================================================

# picoblaze_interrupt_controller

Interrupt controller sitting between peripheral event sources (1 Hz tick, audio-sample strobe, keyboard/flash done pulses) and the single `interrupt`/`interrupt_ack` pair of the pacoblaze3 core. It latches rising edges from up to 8 sources into a pending register and applies a CPU-writable mask. It presents one level interrupt to the core and, on acknowledge, selects the highest-priority source into a readable vector register. It attaches to the core's port_id/strobe I/O bus as a set of registered I/O ports.

## Interface
Parameters:
- NUM_SRC, 4: number of interrupt sources, 1..8.
- ADDR_MASK, 8'h10: port address of the mask register (read/write).
- ADDR_PEND, 8'h11: port address of pending (read; write-1-to-clear).
- ADDR_VEC, 8'h12: port address of vector (read only).
- ADDR_EOI, 8'h13: port address of end-of-interrupt (write, data ignored).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  NUM_SRC  event sources, synchronous to clk; rising edge = event.
- port_id  in  8  core port address.
- out_port  in  8  core write data.
- write_strobe  in  1  core write qualifier.
- read_strobe  in  1  core read qualifier (informational; reads are non-destructive).
- interrupt_ack  in  1  core acknowledge pulse.
- interrupt  out  1  level interrupt request to the core.
- rd_data  out  8  registered read data, to be ORed/muxed into the core in_port.

## Operation
- Edge detect: a per-source previous-value flop; event = irq_src & ~prev.
- pending[i] is set by an event and cleared by a W1C write to ADDR_PEND (bit i = 1) or by being selected at ack. A set in the same cycle as any clear wins; pending stays 1.
- mask[NUM_SRC-1:0] is written from out_port on write_strobe && port_id==ADDR_MASK. Unused upper bits read 0.
- States: IDLE (in_service=0), REQ (interrupt=1), SERVICE (in_service=1).
- IDLE→REQ when (pending & mask)!=0. REQ→IDLE if the masked pending set becomes empty before ack. REQ→SERVICE on interrupt_ack: vector ← index of the lowest-numbered masked pending bit; that bit clears; interrupt drops.
- SERVICE→IDLE on a write to ADDR_EOI. No new interrupt is raised in SERVICE (no nesting). interrupt_ack outside REQ is ignored.
- Reads: rd_data ← mask / pending / {4'h0, vector} for a matching port_id; otherwise 8'h00. Address decode is full 8-bit.

## Timing
- Reset values: interrupt=0, rd_data=8'h00, mask=0, pending=0, vector=8'h00, in_service=0, prev=0. An async assert mid-service clears everything immediately. A source held high across reset release produces no event.
- Event latency: irq_src rises at edge n; pending is set after edge n+1; interrupt is high after edge n+2.
- interrupt is a registered output. It holds high until ack or until the masked pending set empties. It is low the cycle after the ack edge.
- Vector is valid the cycle after ack. The EOI write at edge m allows interrupt to re-assert after edge m+1 if work remains.
- Read latency: 1 cycle. rd_data reflects the register value sampled at the edge where port_id was presented, matching the core's pipelined input mux.
- A write and a read of the same register in the same cycle return the pre-write value.

## Structure
- A shared Verilog header holds the default port-address localparams and NUM_SRC_MAX=8, so the core I/O decode and the PSM constants stay in sync.
- Sub-module `irq_edge_detect`: a NUM_SRC-wide prev register plus rising-edge output.
- A priority encoder, FSM and register file make up the top level.

## Test plan
- Reset: assert reset mid-SERVICE → interrupt=0, rd_data=0; reading ADDR_MASK/ADDR_PEND/ADDR_VEC returns 8'h00.
- Single event: mask=8'h0F, pulse irq_src[2] → interrupt high 2 cycles later; ack → interrupt low next cycle, ADDR_VEC=8'h02, ADDR_PEND=8'h00.
- Priority: events on src1 and src3 in the same cycle → ack gives vector 1. EOI → interrupt re-asserts; ack gives vector 3.
- Masking: mask=8'h00, pulse src0 → pending=8'h01, interrupt stays 0. Write mask=8'h01 → interrupt high 1 cycle later.
- W1C race: pending=8'h05. Write 8'h05 to ADDR_PEND in the same cycle as a new src2 edge → pending=8'h04.
- No nesting and spurious ack: a src0 event during SERVICE leaves interrupt at 0 until EOI. An interrupt_ack in IDLE leaves vector and pending unchanged.

Source files
------------

// File: rtl/picoblaze_interrupt_controller_pkg.sv
// Shared constants and types for the pacoblaze3 interrupt controller.
// The default port addresses live here so the I/O decode and PSM constants agree.
package picoblaze_interrupt_controller_pkg;

  localparam int         NUM_SRC_MAX   = 8;
  localparam logic [7:0] DEF_ADDR_MASK = 8'h10;
  localparam logic [7:0] DEF_ADDR_PEND = 8'h11;
  localparam logic [7:0] DEF_ADDR_VEC  = 8'h12;
  localparam logic [7:0] DEF_ADDR_EOI  = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } irq_state_t;

  // Index of the lowest set bit; bit 0 is the highest priority source.
  function automatic logic [3:0] lowest_idx(input logic [NUM_SRC_MAX-1:0] v);
    lowest_idx = 4'd0;
    for (int i = NUM_SRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/picoblaze_interrupt_controller_irq_edge_detect.sv
// Rising-edge detector for the interrupt sources.
// The first edge after reset only primes prev, so a source already high
// when reset releases does not register as an event.
module irq_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] src,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;
  logic         armed;

  // Track the previous source level and arm after the first post-reset edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= src;
      armed <= 1'b1;
    end
  end

  assign rise = armed ? (src & ~prev) : '0;

endmodule

// File: rtl/picoblaze_interrupt_controller.sv
// Interrupt controller for the pacoblaze3 core: latches source edges into a
// pending register, applies a CPU mask, raises one level interrupt and hands
// the highest-priority source index to the CPU on acknowledge.
module picoblaze_interrupt_controller
  import picoblaze_interrupt_controller_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter logic [7:0] ADDR_PEND = DEF_ADDR_PEND,
  parameter logic [7:0] ADDR_VEC  = DEF_ADDR_VEC,
  parameter logic [7:0] ADDR_EOI  = DEF_ADDR_EOI
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [7:0]         rd_data
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] sel;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] clr;
  logic [3:0]         vector;
  irq_state_t         state;
  logic               wr_mask;
  logic               wr_pend;
  logic               wr_eoi;
  logic               ack_take;
  logic               unused;

  // Reads have no side effects, and out_port bits above NUM_SRC carry nothing.
  assign unused = ^{read_strobe, out_port};

  irq_edge_detect #(.W(NUM_SRC)) u_edge (
    .clk   (clk),
    .reset (reset),
    .src   (irq_src),
    .rise  (rise)
  );

  assign wr_mask  = write_strobe && (port_id == ADDR_MASK);
  assign wr_pend  = write_strobe && (port_id == ADDR_PEND);
  assign wr_eoi   = write_strobe && (port_id == ADDR_EOI);

  assign act      = pending & mask;
  // Isolate the lowest set bit of the masked pending set.
  assign sel      = act & (~act + NUM_SRC'(1));
  assign ack_take = (state == ST_REQ) && interrupt_ack && (act != '0);
  assign w1c      = wr_pend ? out_port[NUM_SRC-1:0] : '0;
  assign clr      = w1c | (ack_take ? sel : '0);

  // Mask and pending registers; a new event outranks any clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      if (wr_mask) mask <= out_port[NUM_SRC-1:0];
      pending <= (pending & ~clr) | rise;
    end
  end

  // Request/service FSM with registered interrupt and vector capture on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      vector    <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (act != '0) begin
            state     <= ST_REQ;
            interrupt <= 1'b1;
          end
        end
        ST_REQ: begin
          if (act == '0) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
          end else if (interrupt_ack) begin
            state     <= ST_SERVICE;
            interrupt <= 1'b0;
            vector    <= lowest_idx(8'(act));
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

  // Registered read mux; samples register values before any same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (port_id == ADDR_MASK) begin
      rd_data <= 8'(mask);
    end else if (port_id == ADDR_PEND) begin
      rd_data <= 8'(pending);
    end else if (port_id == ADDR_VEC) begin
      rd_data <= {4'h0, vector};
    end else begin
      rd_data <= 8'h00;
    end
  end

endmodule

// File: tb/tb_picoblaze_interrupt_controller.sv
// Directed bench for picoblaze_interrupt_controller with a behavioural model
// checked every cycle, plus literal expectations at the key points.
module tb_picoblaze_interrupt_controller;

  localparam int         NSRC = 4;
  localparam logic [7:0] A_MASK = 8'h10;
  localparam logic [7:0] A_PEND = 8'h11;
  localparam logic [7:0] A_VEC  = 8'h12;
  localparam logic [7:0] A_EOI  = 8'h13;
  localparam logic [7:0] SRCM   = 8'h0F;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] irq_src = '0;
  logic [7:0]      port_id = 8'h00;
  logic [7:0]      out_port = 8'h00;
  logic            write_strobe = 1'b0;
  logic            read_strobe = 1'b0;
  logic            interrupt_ack = 1'b0;
  logic            interrupt;
  logic [7:0]      rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  picoblaze_interrupt_controller #(.NUM_SRC(NSRC)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .interrupt     (interrupt),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for work, 1 = requesting, 2 = handler running
  int       m_mode;
  bit [7:0] m_pend, m_mask, m_vec, m_rd, m_prev;
  bit       m_int, m_fresh;

  initial begin : model
    bit [7:0] src8, ev, act, clr;
    m_mode = 0; m_pend = 0; m_mask = 0; m_vec = 0; m_rd = 0; m_prev = 0;
    m_int = 0; m_fresh = 1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = 0; m_pend = 0; m_mask = 0; m_vec = 0; m_rd = 0; m_prev = 0;
        m_int = 0; m_fresh = 1;
      end else begin
        src8 = 8'(irq_src);
        ev   = m_fresh ? 8'h00 : (src8 & ~m_prev);
        m_prev = src8;
        m_fresh = 0;
        act = m_pend & m_mask;
        if (port_id == A_MASK)      m_rd = m_mask;
        else if (port_id == A_PEND) m_rd = m_pend;
        else if (port_id == A_VEC)  m_rd = m_vec;
        else                        m_rd = 8'h00;
        clr = (write_strobe && port_id == A_PEND) ? (out_port & SRCM) : 8'h00;
        if (m_mode == 0) begin
          if (act != 0) begin m_mode = 1; m_int = 1; end
        end else if (m_mode == 1) begin
          if (act == 0) begin
            m_mode = 0; m_int = 0;
          end else if (interrupt_ack) begin
            m_mode = 2; m_int = 0;
            for (int i = 0; i < 8; i++) if (act[i]) begin m_vec = 8'(i); break; end
            clr = clr | (8'h01 << m_vec);
          end
        end else begin
          if (write_strobe && port_id == A_EOI) m_mode = 0;
        end
        m_pend = (m_pend & ~clr) | ev;
        if (write_strobe && port_id == A_MASK) m_mask = out_port & SRCM;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  initial begin : cmp
    forever begin
      @(negedge clk);
      chk("model_interrupt", {7'd0, interrupt}, {7'd0, m_int});
      chk("model_rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    port_id = a; read_strobe = 1'b1;
    cyc();
    chk(name, rd_data, exp);
    read_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] b);
    irq_src = irq_src | b;
    cyc();
    irq_src = irq_src & ~b;
  endtask

  task automatic chk_int(input string name, input logic exp);
    chk(name, {7'd0, interrupt}, {7'd0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    #2 reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();

    // reset state
    chk_int("rst_int", 1'b0);
    rd_chk("rst_mask", A_MASK, 8'h00);
    rd_chk("rst_pend", A_PEND, 8'h00);
    rd_chk("rst_vec", A_VEC, 8'h00);

    // single event on src2
    wr(A_MASK, 8'h0F);
    rd_chk("mask_rb", A_MASK, 8'h0F);
    pulse(4'b0100);
    chk_int("single_lat1", 1'b0);
    cyc();
    chk_int("single_lat2", 1'b1);
    ack();
    chk_int("single_ackdrop", 1'b0);
    rd_chk("single_vec", A_VEC, 8'h02);
    rd_chk("single_pend", A_PEND, 8'h00);
    wr(A_EOI, 8'h00);
    cyc();

    // priority: src1 and src3 together
    pulse(4'b1010);
    cyc();
    chk_int("prio_req", 1'b1);
    ack();
    rd_chk("prio_vec1", A_VEC, 8'h01);
    rd_chk("prio_pend", A_PEND, 8'h08);
    wr(A_EOI, 8'h00);
    chk_int("prio_eoi_m", 1'b0);
    cyc();
    chk_int("prio_eoi_m1", 1'b1);
    ack();
    rd_chk("prio_vec3", A_VEC, 8'h03);
    wr(A_EOI, 8'h00);
    cyc();

    // masking
    wr(A_MASK, 8'h00);
    pulse(4'b0001);
    cyc();
    rd_chk("mask_pend", A_PEND, 8'h01);
    chk_int("mask_noint", 1'b0);
    wr(A_MASK, 8'h01);
    chk_int("unmask_m", 1'b0);
    cyc();
    chk_int("unmask_m1", 1'b1);
    ack();
    rd_chk("unmask_vec", A_VEC, 8'h00);
    wr(A_EOI, 8'h00);

    // W1C racing a new src2 edge
    wr(A_MASK, 8'h00);
    pulse(4'b0101);
    rd_chk("w1c_pre", A_PEND, 8'h05);
    port_id = A_PEND; out_port = 8'h05; write_strobe = 1'b1; irq_src = 4'b0100;
    cyc();
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00; irq_src = 4'b0000;
    rd_chk("w1c_race", A_PEND, 8'h04);
    wr(A_PEND, 8'hFF);
    rd_chk("w1c_clear", A_PEND, 8'h00);

    // no nesting while in service
    wr(A_MASK, 8'h0F);
    pulse(4'b0100);
    cyc();
    ack();
    pulse(4'b0001);
    cyc(); cyc();
    chk_int("nest_hold", 1'b0);
    rd_chk("nest_pend", A_PEND, 8'h01);
    wr(A_EOI, 8'h00);
    cyc();
    chk_int("nest_after_eoi", 1'b1);
    ack();
    wr(A_EOI, 8'h00);

    // spurious ack in idle
    pulse(4'b0100);
    cyc();
    ack();
    wr(A_EOI, 8'h00);
    wr(A_MASK, 8'h00);
    pulse(4'b0001);
    cyc();
    ack();
    rd_chk("spur_vec", A_VEC, 8'h02);
    rd_chk("spur_pend", A_PEND, 8'h01);
    chk_int("spur_int", 1'b0);
    wr(A_PEND, 8'hFF);

    // async reset mid-service with a source held high across release
    wr(A_MASK, 8'h0F);
    pulse(4'b1000);
    cyc();
    ack();
    rd_chk("svc_vec", A_VEC, 8'h03);
    #2 reset = 1'b1;
    irq_src = 4'b0010;
    #1;
    chk_int("arst_int", 1'b0);
    chk("arst_rd", rd_data, 8'h00);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk_int("held_noint", 1'b0);
    rd_chk("held_pend", A_PEND, 8'h00);
    rd_chk("arst_mask", A_MASK, 8'h00);
    rd_chk("arst_vec", A_VEC, 8'h00);
    irq_src = 4'b0000;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
